ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage iterative multiply/divide unit with architectural HI/LO registers.
//  Sits directly downstream of the ID/EX pipeline register: takes the rs/rt operands and a decoded muldiv op.
//  Runs MULT/MULTU/DIV/DIVU/MADD/MSUB over WIDTH cycles and exports BusyOut, which the hazard unit
//  uses to stall MFHI/MFLO and any further muldiv op.
// PARAMETERS
//  WIDTH    32            operand width; iteration count = WIDTH
//  DIV0_LO  32'hFFFFFFFF  LO value written on divide-by-zero
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  Reset      in   1      asynchronous, active-high reset
//  StartIn    in   1      op valid this cycle (ID/EX output stage)
//  MdOpIn     in   4      0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MADD,6 MSUB,7 MTHI,8 MTLO; 9-15 = none
//  RsIn       in   WIDTH  operand A / dividend / MTHI-MTLO data
//  RtIn       in   WIDTH  operand B / divisor
//  BusyOut    out  1      iterative op in flight
//  DoneOut    out  1      one-cycle pulse: HI/LO updated by iterative op
//  HiOut      out  WIDTH  HI register
//  LoOut      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, any time, incl. mid-op): HI=0, LO=0, BusyOut=0, DoneOut=0, counter=0, op aborted, no partial write.
//  Accept: StartIn=1 && BusyOut=0 && op!=none, sampled on rising edge T.
//    - Ops 9-15 and op 0 are ignored.
//  MTHI/MTLO: HI (resp. LO) <= RsIn at edge T; BusyOut stays 0; no DoneOut.
//  Iterative ops: operands latched at T; BusyOut=1 from T for exactly WIDTH cycles.
//    - At edge T+WIDTH: HI/LO written, BusyOut->0, DoneOut=1 for that one cycle.
//    - New results are visible when DoneOut=1.
//  MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product; radix-2 shift-add, one bit per cycle.
//  MADD/MSUB: {HI,LO} = {HI,LO} +/- signed(Rs*Rt), mod 2^64.
//    - Uses the HI/LO value sampled at T.
//  DIV/DIVU: restoring division on magnitudes; LO=quotient, HI=remainder.
//    - Quotient truncates toward zero; remainder takes the sign of the dividend.
//  Divide by zero: normal latency, HI=RsIn, LO=DIV0_LO; signed and unsigned alike.
//  DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap); no exception.
//  StartIn while BusyOut=1: ignored; no state change.
//    - The hazard unit must prevent this; an assertion flags it.
//  HiOut/LoOut hold their prior values throughout an op; no intermediate values appear on them.
//  Back-to-back ops: a new op may be accepted in the DoneOut cycle (BusyOut already 0).
//    - That op starts with the just-written HI/LO.
//  Counter is ceil(log2(WIDTH+1)) bits; no wrap.
// STRUCTURE
//  md_pkg: md_op_e enum (values above), WIDTH default, DIV0_LO constant, is_iter(op) function.
//  Sub-module md_iter_core: shift/add-sub datapath + counter.
//    - Inputs: start, signed flag, div flag, operands.
//    - Outputs: 64-bit result, done.
//  Top level holds the HI/LO registers, op decode, sign pre/post-correction, MADD/MSUB accumulate.
// TESTING
//  1. Reset mid-MULT (cycle 10 of 32) -> HI=LO=0, Busy=0 immediately; no DoneOut follows.
//  2. MULT -3 x 7 at T -> Busy T..T+31, DoneOut at T+32, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU 7/0 -> HI=7, LO=0xFFFFFFFF.
//  4. MTHI 5, MTLO 9, then MADD 2x3 -> HI=5, LO=15.
//     MSUB 1x16 -> HI=4, LO=0xFFFFFFFF.
//  5. MULTU 0xFFFFFFFF^2 -> HI=0xFFFFFFFE, LO=1.
//     Second StartIn during Busy -> ignored, assertion fires.
//  6. Op issued in DoneOut cycle -> accepted, Busy rises next cycle; op=12 -> no effect.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types, constants and helpers for the EX-stage multiply/divide unit.
package md_pkg;

  localparam int unsigned MD_WIDTH   = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFFFFFF;

  // Decoded muldiv operation; encodings 9-15 are treated as no-op.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // Sequencer state: idle or iterating.
  typedef enum logic {
    MD_ST_IDLE = 1'b0,
    MD_ST_RUN  = 1'b1
  } md_state_e;

  // True for ops that run through the iterative core.
  function automatic logic is_iter(input logic [3:0] op);
    return (op >= 4'(MD_MULT)) && (op <= 4'(MD_MSUB));
  endfunction

  // True for any op that does something (iterative or HI/LO move).
  function automatic logic is_valid(input logic [3:0] op);
    return (op >= 4'(MD_MULT)) && (op <= 4'(MD_MTLO));
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned radix-2 shift-add multiplier / restoring divider, one bit per cycle.
// The final step is presented combinationally on result while done is high, so the
// caller can capture it on the WIDTH-th edge after start.
module md_iter_core
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 isDiv,
  input  logic [WIDTH-1:0]     opA,
  input  logic [WIDTH-1:0]     opB,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]        cnt;
  logic                 divMode;
  logic [WIDTH-1:0]     operand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   accStep;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       divShift;
  logic [WIDTH:0]       divDiff;
  logic                 divGe;
  logic [WIDTH-1:0]     divRem;

  // One iteration of either algorithm applied to the current accumulator.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divDiff  = divShift - {1'b0, operand};
    divGe    = (divShift >= {1'b0, operand});
    divRem   = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
    if (divMode) begin
      accStep = {divRem, acc[WIDTH-2:0], divGe};
    end else begin
      accStep = {mulSum, acc[WIDTH-1:1]};
    end
  end

  assign result = accStep;
  assign done   = (cnt == CW'(1));

  // Operand latch on start, then iterate until the counter drains.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      divMode <= 1'b0;
      operand <= '0;
      acc     <= '0;
    end else if (start) begin
      cnt     <= CW'(WIDTH);
      divMode <= isDiv;
      operand <= isDiv ? opB : opA;
      acc     <= isDiv ? {WIDTH'(0), opA} : {WIDTH'(0), opB};
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= accStep;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, op decode, sign handling and
// MADD/MSUB accumulation around the iterative core.
module ex_muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned      WIDTH   = MD_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = WIDTH'(MD_DIV0_LO)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             StartIn,
  input  logic [3:0]       MdOpIn,
  input  logic [WIDTH-1:0] RsIn,
  input  logic [WIDTH-1:0] RtIn,
  output logic             BusyOut,
  output logic             DoneOut,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  md_state_e          stateQ;
  md_state_e          stateNext;
  logic               busy;
  logic               accept;
  logic               iterStart;
  logic               opSigned;
  logic               opIsDiv;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;

  logic [3:0]         opQ;
  logic               negQ;
  logic               negR;
  logic               div0Q;
  logic [WIDTH-1:0]   rsQ;
  logic [WIDTH-1:0]   hiQ;
  logic [WIDTH-1:0]   loQ;
  logic               doneQ;

  logic [2*WIDTH-1:0] coreRes;
  logic               coreDone;
  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0]   quoS;
  logic [WIDTH-1:0]   remS;
  logic [2*WIDTH-1:0] newHiLo;

  // Op decode and operand magnitudes for the unsigned core.
  always_comb begin
    accept    = StartIn && !busy && is_valid(MdOpIn);
    iterStart = accept && is_iter(MdOpIn);
    opSigned  = (MdOpIn == MD_MULT) || (MdOpIn == MD_DIV) ||
                (MdOpIn == MD_MADD) || (MdOpIn == MD_MSUB);
    opIsDiv   = (MdOpIn == MD_DIV) || (MdOpIn == MD_DIVU);
    magA      = (opSigned && RsIn[WIDTH-1]) ? -RsIn : RsIn;
    magB      = (opSigned && RtIn[WIDTH-1]) ? -RtIn : RtIn;
  end

  md_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .Reset  (Reset),
    .start  (iterStart),
    .isDiv  (opIsDiv),
    .opA    (magA),
    .opB    (magB),
    .result (coreRes),
    .done   (coreDone)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stateQ <= MD_ST_IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Sequencer next state: run from accept until the core finishes.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      MD_ST_IDLE: if (iterStart) stateNext = MD_ST_RUN;
      MD_ST_RUN:  if (coreDone)  stateNext = MD_ST_IDLE;
      default:    stateNext = MD_ST_IDLE;
    endcase
  end

  // Sequencer outputs.
  always_comb begin
    busy = 1'b0;
    if (stateQ == MD_ST_RUN) busy = 1'b1;
  end

  // Sign post-correction and final HI/LO value for the op in flight.
  always_comb begin
    prodS = negQ ? -coreRes : coreRes;
    quoS  = negQ ? -coreRes[WIDTH-1:0] : coreRes[WIDTH-1:0];
    remS  = negR ? -coreRes[2*WIDTH-1:WIDTH] : coreRes[2*WIDTH-1:WIDTH];
    case (opQ)
      MD_MADD:          newHiLo = {hiQ, loQ} + prodS;
      MD_MSUB:          newHiLo = {hiQ, loQ} - prodS;
      MD_DIV, MD_DIVU:  newHiLo = div0Q ? {rsQ, DIV0_LO} : {remS, quoS};
      default:          newHiLo = prodS;
    endcase
  end

  // Capture op context at accept; sign flags are zero for unsigned ops.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      opQ   <= 4'(MD_NONE);
      negQ  <= 1'b0;
      negR  <= 1'b0;
      div0Q <= 1'b0;
      rsQ   <= '0;
    end else if (iterStart) begin
      opQ   <= MdOpIn;
      negQ  <= opSigned && (RsIn[WIDTH-1] ^ RtIn[WIDTH-1]);
      negR  <= opSigned && RsIn[WIDTH-1];
      div0Q <= (RtIn == '0);
      rsQ   <= RsIn;
    end
  end

  // Architectural HI/LO: written only on completion or by an accepted move.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      hiQ   <= '0;
      loQ   <= '0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= coreDone && busy;
      if (coreDone && busy) begin
        {hiQ, loQ} <= newHiLo;
      end else if (accept && (MdOpIn == MD_MTHI)) begin
        hiQ <= RsIn;
      end else if (accept && (MdOpIn == MD_MTLO)) begin
        loQ <= RsIn;
      end
    end
  end

  assign BusyOut = busy;
  assign DoneOut = doneQ;
  assign HiOut   = hiQ;
  assign LoOut   = loQ;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a vector table for the iterative ops plus
// hand-written sequences for reset, overlap and back-to-back corners.
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         Reset;
  logic         StartIn;
  logic [3:0]   MdOpIn;
  logic [W-1:0] RsIn;
  logic [W-1:0] RtIn;
  logic         BusyOut;
  logic         DoneOut;
  logic [W-1:0] HiOut;
  logic [W-1:0] LoOut;

  int total  = 0;
  int passed = 0;
  int illegalCnt = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] preHi;
    logic [W-1:0] preLo;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .StartIn (StartIn),
    .MdOpIn  (MdOpIn),
    .RsIn    (RsIn),
    .RtIn    (RtIn),
    .BusyOut (BusyOut),
    .DoneOut (DoneOut),
    .HiOut   (HiOut),
    .LoOut   (LoOut)
  );

  always #5 clk = ~clk;

  // Protocol monitor: a valid op offered while busy is a hazard-unit violation.
  always @(posedge clk) begin
    if (!Reset && StartIn && BusyOut && (MdOpIn >= 4'd1) && (MdOpIn <= 4'd8))
      illegalCnt++;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge, then drop StartIn.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    StartIn = 1'b1;
    MdOpIn  = op;
    RsIn    = rs;
    RtIn    = rt;
    step();
    StartIn = 1'b0;
    MdOpIn  = 4'd0;
  endtask

  // Wait (bounded) for DoneOut; report cycles taken and any HI/LO movement meanwhile.
  task automatic waitDone(input logic [W-1:0] hHold, input logic [W-1:0] lHold,
                          output int cyc, output int holdErr);
    cyc = 0;
    holdErr = 0;
    while (!DoneOut && cyc < 100) begin
      if (HiOut !== hHold || LoOut !== lHold || BusyOut !== 1'b1) holdErr++;
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int holdErr;
    int doneSeen;

    vecs[0]  = '{4'd1, 32'hFFFFFFFD, 32'd7,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{4'd4, 32'd7,        32'd0,        32'd0, 32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[3]  = '{4'd5, 32'd2,        32'd3,        32'd5, 32'd9,        32'd5,        32'd15};
    vecs[4]  = '{4'd6, 32'd1,        32'd16,       32'd5, 32'd15,       32'd4,        32'hFFFFFFFF};
    vecs[5]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'd1};
    vecs[6]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd3, 32'd3,        32'd0,        32'h80000000};
    vecs[7]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,        32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{4'd3, 32'hFFFFFFFB, 32'd0,        32'd0, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{4'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd0,        32'h40000000, 32'd0};
    vecs[10] = '{4'd4, 32'd100,      32'd7,        32'd0, 32'd0,        32'd2,        32'd14};
    vecs[11] = '{4'd5, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[12] = '{4'd6, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0,        32'd0,        32'd6};

    Reset = 1'b1; StartIn = 1'b0; MdOpIn = 4'd0; RsIn = '0; RtIn = '0;
    step(); step();
    chk("reset_busy", 64'(BusyOut), 64'd0);
    chk("reset_done", 64'(DoneOut), 64'd0);
    chk("reset_hilo", {HiOut, LoOut}, 64'd0);
    Reset = 1'b0;
    step();

    // Reset in the middle of a MULT: clears immediately, no completion later.
    issue(4'd7, 32'h1234, 32'd0);
    issue(4'd8, 32'h5678, 32'd0);
    issue(4'd1, 32'd9, 32'd9);
    for (int i = 0; i < 9; i++) step();
    chk("midop_busy_before", 64'(BusyOut), 64'd1);
    Reset = 1'b1;
    #1;
    chk("midop_rst_busy", 64'(BusyOut), 64'd0);
    chk("midop_rst_hilo", {HiOut, LoOut}, 64'd0);
    step();
    Reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (DoneOut) doneSeen++;
      step();
    end
    chk("midop_no_done", 64'(doneSeen), 64'd0);
    chk("midop_hilo_after", {HiOut, LoOut}, 64'd0);

    // Table: preload HI/LO, run the op, check latency, hold, result and pulse width.
    for (int v = 0; v < NV; v++) begin
      issue(4'd7, vecs[v].preHi, 32'd0);
      issue(4'd8, vecs[v].preLo, 32'd0);
      chk($sformatf("v%0d_preload", v), {HiOut, LoOut}, {vecs[v].preHi, vecs[v].preLo});
      issue(vecs[v].op, vecs[v].rs, vecs[v].rt);
      waitDone(vecs[v].preHi, vecs[v].preLo, cyc, holdErr);
      chk($sformatf("v%0d_latency", v), 64'(cyc), 64'(W));
      chk($sformatf("v%0d_hold", v), 64'(holdErr), 64'd0);
      chk($sformatf("v%0d_busy_at_done", v), 64'(BusyOut), 64'd0);
      chk($sformatf("v%0d_hilo", v), {HiOut, LoOut}, {vecs[v].expHi, vecs[v].expLo});
      step();
      chk($sformatf("v%0d_done_pulse", v), 64'(DoneOut), 64'd0);
    end

    // Start offered while busy: ignored, flagged by the monitor.
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'd0, 32'd0);
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) step();
    issue(4'd7, 32'hDEAD, 32'd0);
    chk("ovl_hi_unchanged", 64'(HiOut), 64'd0);
    chk("ovl_still_busy", 64'(BusyOut), 64'd1);
    waitDone(32'd0, 32'd0, cyc, holdErr);
    chk("ovl_latency", 64'(cyc), 64'(W - 5));
    chk("ovl_hilo", {HiOut, LoOut}, 64'hFFFFFFFE_00000001);
    chk("ovl_flagged", 64'(illegalCnt), 64'd1);

    // Back-to-back: MADD issued in the DoneOut cycle starts from the fresh HI/LO.
    step();
    issue(4'd1, 32'd2, 32'd3);
    waitDone(32'hFFFFFFFE, 32'd1, cyc, holdErr);
    chk("b2b_first", {HiOut, LoOut}, 64'd6);
    chk("b2b_done_cycle", 64'(DoneOut), 64'd1);
    issue(4'd5, 32'd1, 32'd1);
    chk("b2b_busy_rise", 64'(BusyOut), 64'd1);
    waitDone(32'd0, 32'd6, cyc, holdErr);
    chk("b2b_latency", 64'(cyc), 64'(W));
    chk("b2b_result", {HiOut, LoOut}, 64'd7);
    step();

    // Reserved opcode: no busy, no HI/LO change, no done.
    issue(4'd12, 32'hAAAA, 32'h5555);
    chk("op12_busy", 64'(BusyOut), 64'd0);
    step();
    chk("op12_done", 64'(DoneOut), 64'd0);
    chk("op12_hilo", {HiOut, LoOut}, 64'd7);
    chk("final_illegal_count", 64'(illegalCnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
